// File: rtl/intirvx_decode_stage_pkg.sv
// Shared CPU constants and the decode control bus seen by every pipeline stage.
// Pure declarations: no logic, no latency.
package cpu_parameters;
  localparam int          EPOCH_WIDTH = 2;
  localparam logic [31:0] START_PC    = 32'h0000_0000;

  typedef logic [EPOCH_WIDTH-1:0] epoch_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
endpackage

package interfaces_pkg;
  typedef struct packed {
    logic       lui;
    logic       auipc;
    logic       jal;
    logic       jalr;
    logic       branch;
    logic       load;
    logic       store;
    logic       op_imm;
    logic       op;
    logic       fence;
    logic       system;
    logic       illegal;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       rd_en;
    logic       rs1_en;
    logic       rs2_en;
  } decode_bus;
endpackage

// File: rtl/intirvx_decode_decoder.sv
// Purely combinational RV32I opcode decoder; zero latency, no flow control.
// Register enables ignore x0 so hazard logic never waits on it.
module intirvx_decode_decoder
  import cpu_parameters::*;
  import interfaces_pkg::*;
(
  input  logic [31:0] inst_i,
  output decode_bus   dec_o
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       rd_nz;
  logic       rs1_nz;
  logic       rs2_nz;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign rd_nz  = inst_i[11:7]  != 5'd0;
  assign rs1_nz = inst_i[19:15] != 5'd0;
  assign rs2_nz = inst_i[24:20] != 5'd0;

  always_comb begin
    dec_o          = '0;
    dec_o.funct3   = funct3;
    dec_o.funct7b5 = inst_i[30];
    case (opcode)
      OPC_LUI:    begin dec_o.lui   = 1'b1; dec_o.rd_en = rd_nz; end
      OPC_AUIPC:  begin dec_o.auipc = 1'b1; dec_o.rd_en = rd_nz; end
      OPC_JAL:    begin dec_o.jal   = 1'b1; dec_o.rd_en = rd_nz; end
      OPC_JALR: begin
        dec_o.jalr    = 1'b1;
        dec_o.rd_en   = rd_nz;
        dec_o.rs1_en  = rs1_nz;
        dec_o.illegal = funct3 != 3'b000;
      end
      OPC_BRANCH: begin dec_o.branch = 1'b1; dec_o.rs1_en = rs1_nz; dec_o.rs2_en = rs2_nz; end
      OPC_LOAD:   begin dec_o.load   = 1'b1; dec_o.rd_en  = rd_nz;  dec_o.rs1_en = rs1_nz; end
      OPC_STORE:  begin dec_o.store  = 1'b1; dec_o.rs1_en = rs1_nz; dec_o.rs2_en = rs2_nz; end
      OPC_OPIMM:  begin dec_o.op_imm = 1'b1; dec_o.rd_en  = rd_nz;  dec_o.rs1_en = rs1_nz; end
      OPC_OP: begin
        dec_o.op      = 1'b1;
        dec_o.rd_en   = rd_nz;
        dec_o.rs1_en  = rs1_nz;
        dec_o.rs2_en  = rs2_nz;
        // Only SUB/SRA use the alternate funct7 encoding.
        dec_o.illegal = !((funct7 == 7'h00) ||
                          (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OPC_FENCE:  dec_o.fence  = 1'b1;
      OPC_SYSTEM: dec_o.system = 1'b1;
      default:    dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/intirvx_decode_fifo.sv
// Registered FIFO with synchronous clear; entries visible one cycle after push.
// Accepts a push when full only if a pop happens in the same cycle; clear beats push.
module intirvx_decode_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       push_vld_i,
  input  logic [W-1:0]               push_dat_i,
  output logic                       full_o,
  input  logic                       pop_rdy_i,
  output logic                       pop_vld_o,
  output logic [W-1:0]               pop_dat_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o    = cnt_q == CW'(DEPTH);
  assign pop_vld_o = cnt_q != '0;
  assign pop_dat_o = mem_q[rd_q];
  assign count_o   = cnt_q;
  assign do_pop    = pop_vld_o & pop_rdy_i;
  assign do_push   = push_vld_i & (!full_o | do_pop);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wr_q] <= push_dat_i;
  end

endmodule

// File: rtl/intirvx_decode_stage.sv
// Decode stage: decodes fetched instructions into a FIFO (1-cycle min latency) and owns the fetch PC/epoch.
// Backpressure: inst_ready drops when the FIFO is full and not draining; pc holds while pc_ready is low.
module intirvx_decode_stage
  import interfaces_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              ALEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              EPOCH_W  = cpu_parameters::EPOCH_WIDTH,
  parameter int              PC_STEP  = 4,
  parameter logic [ALEN-1:0] START_PC = ALEN'(cpu_parameters::START_PC)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [XLEN-1:0]            inst,
  input  logic [ALEN-1:0]            inst_pc,
  input  logic [EPOCH_W-1:0]         inst_epoch,
  input  logic                       inst_valid,
  output logic                       inst_ready,
  output decode_bus                  decode,
  output logic [24:0]                decode_inst,
  output logic [ALEN-1:0]            decode_pc,
  output logic                       decode_valid,
  input  logic                       decode_ready,
  input  logic                       alu_jump,
  input  logic [ALEN-1:0]            alu_jump_addr,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  output logic [ALEN-1:0]            pc,
  output logic [EPOCH_W-1:0]         pc_epoch,
  output logic                       pc_valid,
  input  logic                       pc_ready,
  output logic                       flush_ifetch,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int FW = $bits(decode_bus) + 25 + ALEN;

  decode_bus                  dec;
  logic                       fifo_full, fifo_vld;
  logic [FW-1:0]              fifo_dat;
  logic [$clog2(DEPTH+1)-1:0] fifo_cnt;
  logic [ALEN-1:0]            pc_q, pc_d, jal_tgt;
  logic [EPOCH_W-1:0]         epoch_q, epoch_d;
  logic                       accept, cur_epoch, alu_redir, jal_redir;

  intirvx_decode_decoder u_decoder (
    .inst_i (inst[31:0]),
    .dec_o  (dec)
  );

  intirvx_decode_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (flush | alu_redir),
    .push_vld_i (cur_epoch),
    .push_dat_i ({dec, inst[31:7], inst_pc}),
    .full_o     (fifo_full),
    .pop_rdy_i  (decode_ready),
    .pop_vld_o  (fifo_vld),
    .pop_dat_o  (fifo_dat),
    .count_o    (fifo_cnt)
  );

  assign {decode, decode_inst, decode_pc} = fifo_dat;
  assign decode_valid = fifo_vld & !rst;
  assign occupancy    = rst ? '0 : fifo_cnt;
  assign inst_ready   = !fifo_full | (decode_valid & decode_ready);
  assign alu_ready    = 1'b1;

  // Stale-epoch instructions are still handshaken so fetch can drain them.
  assign accept    = inst_valid & inst_ready & !rst;
  assign cur_epoch = accept & (inst_epoch == epoch_q);
  assign alu_redir = alu_valid & alu_jump;
  assign jal_redir = cur_epoch & dec.jal & !flush & !alu_redir;
  assign jal_tgt   = inst_pc + {{(ALEN-21){inst[31]}}, inst[31], inst[19:12],
                                inst[20], inst[30:21], 1'b0};

  assign pc           = rst ? START_PC : pc_q;
  assign pc_epoch     = rst ? '0 : epoch_q;
  assign pc_valid     = !rst;
  assign flush_ifetch = (flush | alu_redir | jal_redir) & !rst;

  always_comb begin
    pc_d    = pc_q;
    epoch_d = epoch_q;
    if (flush) begin
      epoch_d = epoch_q + EPOCH_W'(1);
    end else if (alu_redir) begin
      pc_d    = alu_jump_addr;
      epoch_d = epoch_q + EPOCH_W'(1);
    end else if (jal_redir) begin
      pc_d    = jal_tgt;
      epoch_d = epoch_q + EPOCH_W'(1);
    end else if (pc_ready) begin
      pc_d = pc_q + ALEN'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= START_PC;
      epoch_q <= '0;
    end else begin
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
    end
  end

endmodule
